health_tracker: RTL and testbench
=================================

HEALTH_TRACKER -- requirements
Module: health_tracker

Interface
REQ-001 Parameter HEALTH_INIT, default 3'd3, health per player at round start.
REQ-002 Parameter SHIELD_INIT, default 3'd3, shield per player at round start.
REQ-003 Parameter ROUNDS_TO_WIN, default 2'd2, round wins that end the match.
REQ-004 Parameter KO_HOLD, default 6'd60, frames held in KO before the next round.
REQ-005 Parameter REGEN_FRAMES, default 7'd120, idle frames per +1 shield (SHIELD_REGEN_EN only).
REQ-006 Ports: logic_clk in 1, frame clock; reset in 1, synchronous active-high.
REQ-007 round_start in 1, leaves IDLE/OVER for a new match.
REQ-008 p1_stunmode, p2_stunmode in 2, from hit detection: 00 none, 01 hit, 10 block, 11 ignored.
REQ-009 health1, health2 out 3, and shield1, shield2 out 3, current values.
REQ-010 p1_rounds, p2_rounds out 2, round wins; fight_active out 1, high in FIGHT only.
REQ-011 hit_pulse1, hit_pulse2 out 1, one-cycle pulse when that player loses health.
REQ-012 game_over out 1; winner out 2: 00 none, 01 P1, 10 P2.

Function
REQ-013 FSM states: IDLE, FIGHT, KO, OVER; single registered state, all updates on posedge logic_clk.
REQ-014 Event = stunmode transitioning from 00/11 to 01 or 10 (previous-cycle register); a held stunmode counts once.
REQ-015 In FIGHT, hit event on player N: healthN decrements by 1, saturating at 0, and hit_pulseN is asserted next cycle.
REQ-016 In FIGHT, block event with shieldN>0: shieldN decrements by 1; health unchanged.
REQ-017 In FIGHT, block event with shieldN==0 (guard break): handled as a hit.
REQ-018 Events for both players in the same cycle are both applied.
REQ-019 Events outside FIGHT are ignored; no pulses.
REQ-020 IDLE -> FIGHT on round_start: health=HEALTH_INIT, shield=SHIELD_INIT, rounds=0, winner=00.
REQ-021 FIGHT -> KO the cycle after any health reaches 0; exactly one at 0 increments the survivor's round count; both at 0 is a draw with no increment.
REQ-022 KO: counter runs KO_HOLD cycles; then -> OVER if any rounds==ROUNDS_TO_WIN, else -> FIGHT with health and shield reinitialised.
REQ-023 OVER: game_over=1; winner is the player who reached ROUNDS_TO_WIN; state held until round_start -> FIGHT with full match reinit.
REQ-024 round_start in FIGHT or KO is ignored.
REQ-025 Round counters saturate at ROUNDS_TO_WIN.

Reset
REQ-026 Synchronous reset: state=IDLE, health=HEALTH_INIT, shield=SHIELD_INIT, rounds=0, pulses=0, game_over=0, winner=00, counters=0, prev-stunmode=00; reset overrides all other inputs including mid-KO.

Configuration
REQ-027 With SHIELD_REGEN_EN defined: per player, a counter cleared by any event for that player increments each FIGHT cycle; at REGEN_FRAMES it sets shieldN+1 (capped at SHIELD_INIT) and clears.
REQ-028 Without SHIELD_REGEN_EN: shield changes only through REQ-016/020/022; no regen logic is present.

Structure
REQ-029 Shared package game_pkg: stunmode encodings (STUN_NONE/HIT/BLOCK), tracker state encoding, winner encoding.
REQ-030 Sub-module stun_event_detect, instantiated once per player: registers stunmode and outputs hit_evt/block_evt pulses per REQ-014.

Verification
REQ-031 reset, round_start, p2_stunmode=01 for 3 cycles -> health2 3->2 once, one hit_pulse2.
REQ-032 p1_stunmode=10 four separate times -> shield1 3,2,1,0, then health1 2 with hit_pulse1 on the fourth.
REQ-033 Both stunmodes 01 in the same cycle three times -> both health 0, KO, rounds unchanged, FIGHT again after 60 cycles.
REQ-034 P2 health to 0 twice -> p1_rounds=2, OVER, game_over=1, winner=01; round_start -> FIGHT, all reinit.
REQ-035 Reset asserted mid-KO -> IDLE, all outputs at reset values next cycle.
REQ-036 SHIELD_REGEN_EN: shield1=2, 120 event-free FIGHT cycles -> shield1=3; further 120 -> stays 3.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the fighting-game health tracker.
//   stun_e   : per-player stunmode from hit detection
//   state_e  : tracker FSM state
//   winner_e : match winner reported on the winner output
package game_pkg;

    typedef enum logic [1:0] {
        STUN_NONE  = 2'b00,
        STUN_HIT   = 2'b01,
        STUN_BLOCK = 2'b10,
        STUN_IGN   = 2'b11
    } stun_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIGHT = 2'd1,
        ST_KO    = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

endpackage

// File: rtl/stun_event_detect.sv
// Edge detector for one player's stunmode input.
// A hit/block event fires only on the cycle stunmode moves from a quiet
// code (00 or 11) to 01/10, so a held stunmode counts once.
//   clk_i        frame clock
//   reset_i      synchronous active-high reset (clears the history to 00)
//   stunmode_i   raw stunmode from hit detection
//   hit_evt_o    one-cycle hit event (combinational on stunmode_i)
//   block_evt_o  one-cycle block event (combinational on stunmode_i)
module stun_event_detect
    import game_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] stunmode_i,
    output logic       hit_evt_o,
    output logic       block_evt_o
);

    logic [1:0] prev_q;
    logic       prev_quiet;

    assign prev_quiet  = (prev_q == STUN_NONE) || (prev_q == STUN_IGN);
    assign hit_evt_o   = prev_quiet && (stunmode_i == STUN_HIT);
    assign block_evt_o = prev_quiet && (stunmode_i == STUN_BLOCK);

    always_ff @(posedge clk_i) begin
        if (reset_i) prev_q <= STUN_NONE;
        else         prev_q <= stunmode_i;
    end

endmodule

// File: rtl/health_tracker.sv
// Two-player health/shield/round tracker for a fighting game.
// FSM: IDLE -> FIGHT -> KO -> (FIGHT | OVER) -> FIGHT on round_start.
// Optional feature: define SHIELD_REGEN_EN for idle-time shield regeneration
// (one +1 shield per REGEN_FRAMES event-free FIGHT frames, capped at SHIELD_INIT).
// Ports:
//   logic_clk, reset              frame clock, synchronous active-high reset
//   round_start                   starts a new match from IDLE or OVER
//   p1_stunmode, p2_stunmode      00 none, 01 hit, 10 block, 11 ignored
//   health1/2, shield1/2          current values
//   p1_rounds, p2_rounds          round wins
//   fight_active                  high in FIGHT only
//   hit_pulse1/2                  one-cycle pulse when that player loses health
//   game_over, winner             match result (winner 01 P1, 10 P2)
// Internally player 1 is index 0 and player 2 is index 1.
module health_tracker
    import game_pkg::*;
#(
    parameter logic [2:0] HEALTH_INIT   = 3'd3,
    parameter logic [2:0] SHIELD_INIT   = 3'd3,
    parameter logic [1:0] ROUNDS_TO_WIN = 2'd2,
    parameter logic [5:0] KO_HOLD       = 6'd60,
    parameter logic [6:0] REGEN_FRAMES  = 7'd120
) (
    input  logic       logic_clk,
    input  logic       reset,
    input  logic       round_start,
    input  logic [1:0] p1_stunmode,
    input  logic [1:0] p2_stunmode,
    output logic [2:0] health1,
    output logic [2:0] health2,
    output logic [2:0] shield1,
    output logic [2:0] shield2,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic       fight_active,
    output logic       hit_pulse1,
    output logic       hit_pulse2,
    output logic       game_over,
    output logic [1:0] winner
);

    state_e          state_q, state_d;
    logic [1:0][2:0] health_q, health_d;
    logic [1:0][2:0] shield_q, shield_d;
    logic [1:0][1:0] rounds_q, rounds_d;
    logic [1:0]      pulse_q, pulse_d;
    logic [1:0]      winner_q, winner_d;
    logic [5:0]      ko_cnt_q, ko_cnt_d;
    logic [1:0][1:0] stun;
    logic [1:0]      hit_evt, blk_evt;
`ifdef SHIELD_REGEN_EN
    logic [1:0][6:0] regen_q, regen_d;
`endif

    assign stun = {p2_stunmode, p1_stunmode};

    for (genvar i = 0; i < 2; i++) begin : g_det
        stun_event_detect u_det (
            .clk_i      (logic_clk),
            .reset_i    (reset),
            .stunmode_i (stun[i]),
            .hit_evt_o  (hit_evt[i]),
            .block_evt_o(blk_evt[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        health_d = health_q;
        shield_d = shield_q;
        rounds_d = rounds_q;
        pulse_d  = '0;
        winner_d = winner_q;
        ko_cnt_d = ko_cnt_q;
`ifdef SHIELD_REGEN_EN
        regen_d  = regen_q;
        // Any event restarts that player's idle window, in every state.
        for (int i = 0; i < 2; i++)
            if (hit_evt[i] || blk_evt[i]) regen_d[i] = '0;
`endif
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (round_start) begin
                    state_d  = ST_FIGHT;
                    health_d = {HEALTH_INIT, HEALTH_INIT};
                    shield_d = {SHIELD_INIT, SHIELD_INIT};
                    rounds_d = '0;
                    winner_d = WIN_NONE;
`ifdef SHIELD_REGEN_EN
                    regen_d  = '0;
`endif
                end
            end
            ST_FIGHT: begin
                // A zero health seen here closes the round; events arriving
                // in this same frame no longer count.
                if (health_q[0] == 3'd0 || health_q[1] == 3'd0) begin
                    state_d  = ST_KO;
                    ko_cnt_d = '0;
                    if (health_q[0] != 3'd0 && rounds_q[0] != ROUNDS_TO_WIN)
                        rounds_d[0] = rounds_q[0] + 2'd1;
                    else if (health_q[1] != 3'd0 && rounds_q[1] != ROUNDS_TO_WIN)
                        rounds_d[1] = rounds_q[1] + 2'd1;
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        if (blk_evt[i] && shield_q[i] != 3'd0) begin
                            shield_d[i] = shield_q[i] - 3'd1;
                        end else if (hit_evt[i] || blk_evt[i]) begin
                            // Plain hit or guard break.
                            if (health_q[i] != 3'd0) begin
                                health_d[i] = health_q[i] - 3'd1;
                                pulse_d[i]  = 1'b1;
                            end
                        end
`ifdef SHIELD_REGEN_EN
                        else if (regen_q[i] == REGEN_FRAMES - 7'd1) begin
                            regen_d[i] = '0;
                            if (shield_q[i] < SHIELD_INIT)
                                shield_d[i] = shield_q[i] + 3'd1;
                        end else begin
                            regen_d[i] = regen_q[i] + 7'd1;
                        end
`endif
                    end
                end
            end
            ST_KO: begin
                if (ko_cnt_q == KO_HOLD - 6'd1) begin
                    if (rounds_q[0] == ROUNDS_TO_WIN || rounds_q[1] == ROUNDS_TO_WIN) begin
                        state_d  = ST_OVER;
                        winner_d = (rounds_q[0] == ROUNDS_TO_WIN) ? WIN_P1 : WIN_P2;
                    end else begin
                        state_d  = ST_FIGHT;
                        health_d = {HEALTH_INIT, HEALTH_INIT};
                        shield_d = {SHIELD_INIT, SHIELD_INIT};
`ifdef SHIELD_REGEN_EN
                        regen_d  = '0;
`endif
                    end
                end else begin
                    ko_cnt_d = ko_cnt_q + 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge logic_clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            health_q <= {HEALTH_INIT, HEALTH_INIT};
            shield_q <= {SHIELD_INIT, SHIELD_INIT};
            rounds_q <= '0;
            pulse_q  <= '0;
            winner_q <= WIN_NONE;
            ko_cnt_q <= '0;
`ifdef SHIELD_REGEN_EN
            regen_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            health_q <= health_d;
            shield_q <= shield_d;
            rounds_q <= rounds_d;
            pulse_q  <= pulse_d;
            winner_q <= winner_d;
            ko_cnt_q <= ko_cnt_d;
`ifdef SHIELD_REGEN_EN
            regen_q  <= regen_d;
`endif
        end
    end

    assign health1      = health_q[0];
    assign health2      = health_q[1];
    assign shield1      = shield_q[0];
    assign shield2      = shield_q[1];
    assign p1_rounds    = rounds_q[0];
    assign p2_rounds    = rounds_q[1];
    assign hit_pulse1   = pulse_q[0];
    assign hit_pulse2   = pulse_q[1];
    assign winner       = winner_q;
    assign fight_active = (state_q == ST_FIGHT);
    assign game_over    = (state_q == ST_OVER);

endmodule

// File: tb/tb_health_tracker.sv
// Bench for health_tracker: a vector table, directed multi-cycle sequences
// and a long random run compared against a behavioural model of the game rules.
module tb_health_tracker;

    localparam logic [2:0] HI  = 3'd3;
    localparam logic [2:0] SI  = 3'd3;
    localparam logic [1:0] RW  = 2'd2;
    localparam int         KOH = 60;
    localparam int         RGN = 120;

    logic       logic_clk = 1'b0;
    logic       reset = 1'b0, round_start = 1'b0;
    logic [1:0] p1_stunmode = 2'b00, p2_stunmode = 2'b00;
    logic [2:0] health1, health2, shield1, shield2;
    logic [1:0] p1_rounds, p2_rounds, winner;
    logic       fight_active, hit_pulse1, hit_pulse2, game_over;

    health_tracker #(
        .HEALTH_INIT(HI), .SHIELD_INIT(SI), .ROUNDS_TO_WIN(RW),
        .KO_HOLD(6'd60), .REGEN_FRAMES(7'd120)
    ) dut (
        .logic_clk(logic_clk), .reset(reset), .round_start(round_start),
        .p1_stunmode(p1_stunmode), .p2_stunmode(p2_stunmode),
        .health1(health1), .health2(health2), .shield1(shield1), .shield2(shield2),
        .p1_rounds(p1_rounds), .p2_rounds(p2_rounds), .fight_active(fight_active),
        .hit_pulse1(hit_pulse1), .hit_pulse2(hit_pulse2),
        .game_over(game_over), .winner(winner)
    );

    always #5 logic_clk = ~logic_clk;

    int n_pass = 0, n_tot = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- behavioural model (game rules, per-player arrays) ----
    // phase: 0 idle, 1 fight, 2 ko, 3 over
    int mst = 0, mko = 0, mwin = 0;
    int mh[2] = '{3, 3}, ms[2] = '{3, 3}, mr[2] = '{0, 0};
    int mprev[2] = '{0, 0}, mpul[2] = '{0, 0}, mrg[2] = '{0, 0};

    task automatic model_clock();
        int  st[2];
        bit  hit[2], blk[2];
        st[0] = int'(p1_stunmode);
        st[1] = int'(p2_stunmode);
        if (reset) begin
            mst = 0; mko = 0; mwin = 0;
            for (int i = 0; i < 2; i++) begin
                mh[i] = HI; ms[i] = SI; mr[i] = 0; mprev[i] = 0; mpul[i] = 0; mrg[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            hit[i] = (st[i] == 1) && (mprev[i] == 0 || mprev[i] == 3);
            blk[i] = (st[i] == 2) && (mprev[i] == 0 || mprev[i] == 3);
            mpul[i] = 0;
            if (hit[i] || blk[i]) mrg[i] = 0;
        end
        case (mst)
            0, 3: if (round_start) begin
                mst = 1; mwin = 0;
                for (int i = 0; i < 2; i++) begin mh[i] = HI; ms[i] = SI; mr[i] = 0; mrg[i] = 0; end
            end
            1: begin
                if (mh[0] == 0 || mh[1] == 0) begin
                    if (mh[0] != 0)      mr[0] = (mr[0] < RW) ? mr[0] + 1 : mr[0];
                    else if (mh[1] != 0) mr[1] = (mr[1] < RW) ? mr[1] + 1 : mr[1];
                    mst = 2; mko = 0;
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        if (blk[i] && ms[i] > 0) ms[i]--;
                        else if (hit[i] || blk[i]) begin
                            if (mh[i] > 0) begin mh[i]--; mpul[i] = 1; end
                        end
`ifdef SHIELD_REGEN_EN
                        else begin
                            mrg[i]++;
                            if (mrg[i] == RGN) begin mrg[i] = 0; if (ms[i] < SI) ms[i]++; end
                        end
`endif
                    end
                end
            end
            default: begin
                mko++;
                if (mko == KOH) begin
                    if (mr[0] == RW || mr[1] == RW) begin
                        mst = 3; mwin = (mr[0] == RW) ? 1 : 2;
                    end else begin
                        mst = 1;
                        for (int i = 0; i < 2; i++) begin mh[i] = HI; ms[i] = SI; mrg[i] = 0; end
                    end
                end
            end
        endcase
        for (int i = 0; i < 2; i++) mprev[i] = st[i];
    endtask

    function automatic logic [31:0] dut_outs();
        return {10'd0, health1, health2, shield1, shield2, p1_rounds, p2_rounds,
                fight_active, hit_pulse1, hit_pulse2, game_over, winner};
    endfunction

    function automatic logic [31:0] model_outs();
        return {10'd0, 3'(mh[0]), 3'(mh[1]), 3'(ms[0]), 3'(ms[1]), 2'(mr[0]), 2'(mr[1]),
                (mst == 1), 1'(mpul[0]), 1'(mpul[1]), (mst == 3), 2'(mwin)};
    endfunction

    // Inputs are applied between edges; outputs are read 1 time unit after the edge.
    task automatic step();
        model_clock();
        @(posedge logic_clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic hit2();
        p2_stunmode = 2'b01; step();
        p2_stunmode = 2'b00; step();
    endtask

    task automatic hitboth();
        p1_stunmode = 2'b01; p2_stunmode = 2'b01; step();
        p1_stunmode = 2'b00; p2_stunmode = 2'b00; step();
    endtask

    task automatic start_match();
        reset = 1'b1; round_start = 1'b0; p1_stunmode = 2'b00; p2_stunmode = 2'b00; step();
        reset = 1'b0; round_start = 1'b1; step();
        round_start = 1'b0;
    endtask

    typedef struct {
        bit         rst, rs;
        logic [1:0] s1, s2;
        logic [2:0] h1, h2, sh1, sh2;
        bit         p1, p2, f;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(bit rst, bit rs, logic [1:0] s1, logic [1:0] s2,
                                logic [2:0] h1, logic [2:0] h2, logic [2:0] sh1,
                                logic [2:0] sh2, bit p1, bit p2, bit f);
        vec_t v;
        v.rst = rst; v.rs = rs; v.s1 = s1; v.s2 = s2; v.h1 = h1; v.h2 = h2;
        v.sh1 = sh1; v.sh2 = sh2; v.p1 = p1; v.p2 = p2; v.f = f;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Held hit counts once; four blocks drain the shield then break guard;
        // 11 -> 10 is a fresh event.
        tbl[0]  = mk(1, 0, 2'b00, 2'b00, 3, 3, 3, 3, 0, 0, 0);
        tbl[1]  = mk(0, 1, 2'b00, 2'b00, 3, 3, 3, 3, 0, 0, 1);
        tbl[2]  = mk(0, 0, 2'b00, 2'b01, 3, 2, 3, 3, 0, 1, 1);
        tbl[3]  = mk(0, 0, 2'b00, 2'b01, 3, 2, 3, 3, 0, 0, 1);
        tbl[4]  = mk(0, 0, 2'b00, 2'b01, 3, 2, 3, 3, 0, 0, 1);
        tbl[5]  = mk(0, 0, 2'b00, 2'b00, 3, 2, 3, 3, 0, 0, 1);
        tbl[6]  = mk(0, 0, 2'b10, 2'b00, 3, 2, 2, 3, 0, 0, 1);
        tbl[7]  = mk(0, 0, 2'b00, 2'b00, 3, 2, 2, 3, 0, 0, 1);
        tbl[8]  = mk(0, 0, 2'b10, 2'b00, 3, 2, 1, 3, 0, 0, 1);
        tbl[9]  = mk(0, 0, 2'b00, 2'b00, 3, 2, 1, 3, 0, 0, 1);
        tbl[10] = mk(0, 0, 2'b10, 2'b00, 3, 2, 0, 3, 0, 0, 1);
        tbl[11] = mk(0, 0, 2'b00, 2'b00, 3, 2, 0, 3, 0, 0, 1);
        tbl[12] = mk(0, 0, 2'b10, 2'b00, 2, 2, 0, 3, 1, 0, 1);
        tbl[13] = mk(0, 0, 2'b11, 2'b00, 2, 2, 0, 3, 0, 0, 1);
        tbl[14] = mk(0, 0, 2'b10, 2'b00, 1, 2, 0, 3, 1, 0, 1);
        tbl[15] = mk(0, 0, 2'b00, 2'b00, 1, 2, 0, 3, 0, 0, 1);

        for (int i = 0; i < 16; i++) begin
            reset = tbl[i].rst; round_start = tbl[i].rs;
            p1_stunmode = tbl[i].s1; p2_stunmode = tbl[i].s2;
            step();
            check($sformatf("vec%0d", i),
                  {17'd0, health1, health2, shield1, shield2, hit_pulse1, hit_pulse2, fight_active},
                  {17'd0, tbl[i].h1, tbl[i].h2, tbl[i].sh1, tbl[i].sh2, tbl[i].p1, tbl[i].p2, tbl[i].f});
        end

        // Double KO: draw, no round awarded, next round after 60 KO frames.
        start_match();
        hitboth(); hitboth();
        p1_stunmode = 2'b01; p2_stunmode = 2'b01; step();
        check("draw_pulses", {hit_pulse1, hit_pulse2, health1, health2}, {2'b11, 3'd0, 3'd0});
        p1_stunmode = 2'b00; p2_stunmode = 2'b00; step();
        check("draw_ko", {fight_active, p1_rounds, p2_rounds}, {1'b0, 2'd0, 2'd0});
        steps(59);
        check("draw_ko_hold", fight_active, 1'b0);
        step();
        check("draw_next_round", {fight_active, health1, health2, shield1, shield2, p1_rounds, p2_rounds},
              {1'b1, HI, HI, SI, SI, 2'd0, 2'd0});

        // P1 wins the match 2-0.
        start_match();
        hit2(); hit2(); hit2();
        check("r1_ko", {fight_active, p1_rounds, p2_rounds, game_over}, {1'b0, 2'd1, 2'd0, 1'b0});
        steps(60);
        check("r2_fight", {fight_active, health2, p1_rounds}, {1'b1, HI, 2'd1});
        hit2(); hit2(); hit2();
        check("r2_ko", {fight_active, p1_rounds, game_over}, {1'b0, 2'd2, 1'b0});
        steps(60);
        check("over", {fight_active, game_over, winner, p1_rounds, p2_rounds}, {1'b0, 1'b1, 2'b01, 2'd2, 2'd0});
        p1_stunmode = 2'b01; step();
        check("over_no_event", {hit_pulse1, health1}, {1'b0, HI});
        p1_stunmode = 2'b00; steps(3);
        check("over_held", {game_over, winner}, {1'b1, 2'b01});
        round_start = 1'b1; step(); round_start = 1'b0;
        check("rematch", {fight_active, game_over, winner, p1_rounds, p2_rounds, health1, health2, shield1, shield2},
              {1'b1, 1'b0, 2'b00, 2'd0, 2'd0, HI, HI, SI, SI});
        round_start = 1'b1; step(); round_start = 1'b0;
        check("start_in_fight", {fight_active, health1}, {1'b1, HI});

        // Reset in the middle of KO wins over round_start and stunmode.
        start_match();
        hit2(); hit2(); hit2();
        steps(10);
        check("pre_reset_ko", {fight_active, p1_rounds}, {1'b0, 2'd1});
        reset = 1'b1; round_start = 1'b1; p1_stunmode = 2'b01; step();
        check("mid_ko_reset", dut_outs(), {10'd0, HI, HI, SI, SI, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
        reset = 1'b0; round_start = 1'b0; p1_stunmode = 2'b00; step();
        check("idle_after_reset", {fight_active, game_over}, {1'b0, 1'b0});

`ifdef SHIELD_REGEN_EN
        start_match();
        p1_stunmode = 2'b10; step();
        p1_stunmode = 2'b00;
        check("regen_start", shield1, 3'd2);
        steps(119);
        check("regen_not_yet", shield1, 3'd2);
        step();
        check("regen_plus1", shield1, 3'd3);
        steps(120);
        check("regen_capped", shield1, 3'd3);
`endif

        // Random play against the model.
        reset = 1'b1; step(); reset = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            int r1, r2;
            reset       = ($urandom_range(0, 799) == 0);
            round_start = ($urandom_range(0, 24) == 0);
            r1 = $urandom_range(0, 9);
            r2 = $urandom_range(0, 9);
            p1_stunmode = (r1 < 6) ? 2'b00 : 2'(r1 - 6);
            p2_stunmode = (r2 < 6) ? 2'b00 : 2'(r2 - 6);
            step();
            check($sformatf("rand%0d", c), dut_outs(), model_outs());
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
